// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO register pair.
// mult/multu occupy 5 RUN cycles, div/divu 10. The result is computed
// combinationally from the latched operands and committed to HI/LO on the
// final RUN edge. mthi/mtlo write HI/LO directly from IDLE.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } md_op_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  md_op_e      op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        div_zero;
  logic [31:0] a_mag, b_mag, divisor_s, divisor_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  // Result datapath on the latched operands. Signed divide works on
  // magnitudes so that 0x80000000 / -1 yields 0x80000000 without overflow.
  always_comb begin
    prod_s    = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u    = {32'd0, a_q} * {32'd0, b_q};
    div_zero  = (b_q == '0);
    a_mag     = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag     = b_q[31] ? (32'd0 - b_q) : b_q;
    divisor_s = div_zero ? 32'd1 : b_mag;
    divisor_u = div_zero ? 32'd1 : b_q;
    q_mag     = a_mag / divisor_s;
    r_mag     = a_mag % divisor_s;
    q_s       = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
    r_s       = a_q[31] ? (32'd0 - r_mag) : r_mag;
    q_u       = a_q / divisor_u;
    r_u       = a_q % divisor_u;
    res_hi    = hi_q;
    res_lo    = lo_q;
    res_wr    = 1'b1;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_hi = r_s;
        res_lo = q_s;
        res_wr = !div_zero;
      end
      OP_DIVU: begin
        res_hi = r_u;
        res_lo = q_u;
        res_wr = !div_zero;
      end
      default: res_wr = 1'b0;
    endcase
  end

  // Next-state logic: issue from IDLE, count down in RUN, commit on 1->0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (md_op_e'(MDOp))
            OP_MULT, OP_MULTU: begin
              op_d    = md_op_e'(MDOp);
              a_d     = A;
              b_d     = B;
              cnt_d   = 4'd5;
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = md_op_e'(MDOp);
              a_d     = A;
              b_d     = B;
              cnt_d   = 4'd10;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (res_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, latched operands and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
